pc_sequencer: RTL

// - Parametrised fetch PC generator for the single-cycle/multicycle core; replaces the fixed 32-bit PC.
// - Holds PC under multi-source stall, buffers a redirect that arrives while stalled, and takes
//   an exception vector while saving EPC.
// - Feeds instruction memory (PC) and the ALU/link path (PC_Plus_Step).

---
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-PC sequencer bus: stall/redirect/exception requests in, PC/EPC/status out.
// The master modport is the core side; the slave modport is the sequencer.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned N_STALL = 2
);
  logic [N_STALL-1:0] Stall;
  logic               PCSrc;
  logic [ADDR_W-1:0]  Target;
  logic               Exception;
  logic               Call;
  logic               Ret;
  logic [ADDR_W-1:0]  PC;
  logic [ADDR_W-1:0]  PC_Plus_Step;
  logic [ADDR_W-1:0]  EPC;
  logic               Pending;
  logic               Misalign;
  logic               RAS_Empty;

  modport master (
    output Stall, PCSrc, Target, Exception, Call, Ret,
    input  PC, PC_Plus_Step, EPC, Pending, Misalign, RAS_Empty
  );

  modport slave (
    input  Stall, PCSrc, Target, Exception, Call, Ret,
    output PC, PC_Plus_Step, EPC, Pending, Misalign, RAS_Empty
  );
endinterface

// File: rtl/pc_sequencer.sv
// Parametrised fetch PC generator: stall hold, buffered redirect, exception vector with EPC.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       STEP         = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(8),
  parameter int unsigned       N_STALL      = 2,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic           CLK,
  input  logic           Reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    HOLD_P = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(STEP - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic              mis_q, mis_d;

  logic              stall_s;
  logic [ADDR_W-1:0] step_pc_s;
  logic              redir_s;
  logic [ADDR_W-1:0] redir_raw_s;
  logic [ADDR_W-1:0] redir_tgt_s;
  logic              redir_mis_s;

  assign stall_s     = |bus.Stall;
  assign step_pc_s   = pc_q + ADDR_W'(STEP);
  assign redir_tgt_s = redir_raw_s & ~LOW_MASK;
  assign redir_mis_s = |(redir_raw_s & LOW_MASK);

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [PTR_W-1:0]  top_idx_s, wr_idx_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ras_ok_s, pop_s, push_s;

  // Stack moves only on edges where the PC itself advances normally.
  assign ras_ok_s  = !stall_s && !bus.Exception;
  assign pop_s     = ras_ok_s && bus.Ret && (cnt_q != CNT_W'(0));
  assign push_s    = ras_ok_s && bus.Call;
  assign top_idx_s = sp_q - PTR_W'(1);

  // Redirect source: explicit PCSrc wins over a RAS return.
  always_comb begin
    redir_s     = bus.PCSrc || pop_s;
    redir_raw_s = ras_q[top_idx_s];
    if (bus.PCSrc) begin
      redir_raw_s = bus.Target;
    end else begin
      redir_raw_s = ras_q[top_idx_s];
    end
  end

  // Stack pointer/count update; simultaneous pop+push replaces the top entry.
  always_comb begin
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    wr_idx_s = sp_q;
    if (pop_s && push_s) begin
      wr_idx_s = top_idx_s;
    end else if (pop_s) begin
      sp_d  = top_idx_s;
      cnt_d = cnt_q - CNT_W'(1);
    end else if (push_s) begin
      sp_d = sp_q + PTR_W'(1);
      if (cnt_q != CNT_W'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      sp_d = sp_q;
    end
  end

  // Stack pointer and occupancy registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage; contents need no reset since count gates every read.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      ras_q[wr_idx_s] <= step_pc_s;
    end
  end

  assign bus.RAS_Empty = (cnt_q == CNT_W'(0));
`else
  logic unused_ras_s;

  // Without the stack, only explicit PCSrc redirects.
  always_comb begin
    redir_s     = bus.PCSrc;
    redir_raw_s = bus.Target;
  end

  assign unused_ras_s  = bus.Call ^ bus.Ret;
  assign bus.RAS_Empty = 1'b1;
`endif

  // Next-state priority: exception, stalled capture, stall hold, redirect, pending, step.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    pend_d  = pend_q;
    mis_d   = 1'b0;
    if (bus.Exception) begin
      epc_d   = pc_q;
      pc_d    = EXC_VECTOR;
      state_d = RUN;
    end else if (stall_s) begin
      if (redir_s) begin
        pend_d  = redir_tgt_s;
        mis_d   = redir_mis_s;
        state_d = HOLD_P;
      end else if (state_q == HOLD_P) begin
        state_d = HOLD_P;
      end else begin
        state_d = HOLD;
      end
    end else if (redir_s) begin
      pc_d    = redir_tgt_s;
      mis_d   = redir_mis_s;
      state_d = RUN;
    end else if (state_q == HOLD_P) begin
      pc_d    = pend_q;
      state_d = RUN;
    end else begin
      pc_d    = step_pc_s;
      state_d = RUN;
    end
  end

  // Architectural state registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      pend_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      pend_q  <= pend_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.PC           = pc_q;
  assign bus.PC_Plus_Step = step_pc_s;
  assign bus.EPC          = epc_q;
  assign bus.Pending      = (state_q == HOLD_P);
  assign bus.Misalign     = mis_q;

endmodule
